ahb_regfile: RTL and testbench
==============================

# ahb_regfile

Parametrised AHB-Lite slave register file, the next generation of the fixed three-register config block. It provides NUM_REGS 32-bit registers with per-register read-only selection, byte/halfword/word writes, programmable wait states, two-cycle ERROR responses and per-register write pulses. It sits behind the AHB decoder/mux as a leaf slave and feeds configuration and status to function blocks.

## Interface
- NUM_REGS, 8, number of 32-bit registers (1..64)
- ADDR_W, 8, HADDR width; must be >= clog2(NUM_REGS)+2
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only (reads return sts_dat slice i)
- WAIT_CYCLES, 0, wait states inserted on every OKAY transfer (0..15)
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  1  slave select
- HREADY  in  1  bus ready (address phase qualifier)
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HADDR  in  ADDR_W  byte address
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- sts_dat  in  32*NUM_REGS  status values for RO registers, slice i = [32i+31:32i]
- cfg_dat  out  32*NUM_REGS  RW register contents (RO slices drive 0)
- wr_pulse  out  NUM_REGS  one-cycle pulse per register write

## Operation
- Accept: HSEL & HTRANS[1] & HREADY. Latch index = HADDR[ADDR_W-1:2], HWRITE, byte strobes.
- Strobes: HSIZE 0 → 1 lane by HADDR[1:0]; HSIZE 1 → lanes {1,0} or {3,2} by HADDR[1]; HSIZE 2 → all 4.
- Error conditions, checked at accept: index >= NUM_REGS; HSIZE > 2; halfword with HADDR[0]=1; word with HADDR[1:0]≠0; write to RO register. No register change on error.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE/DATA/ERR2: HREADYOUT=1. On accept → ERR1 if error, else WAIT (WAIT_CYCLES>0, counter loaded WAIT_CYCLES-1) or DATA. No accept → IDLE.
  - WAIT: HREADYOUT=0, HRESP=0; counter 0 → DATA else decrement.
  - DATA: HREADYOUT=1, HRESP=0; write commits HWDATA per strobe at this edge.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2. ERR2: HREADYOUT=1, HRESP=1.
- HRDATA: in DATA for read, full 32-bit word of latched index (cfg or sts per RO_MASK), independent of HSIZE; 0 otherwise.
- wr_pulse[i]: registered, high the cycle after the commit edge, aligned with updated cfg_dat.
- BUSY/IDLE HTRANS, HSEL=0 or HREADY=0: not accepted, no side effects.

## Timing
- Reset (HRESET high at edge): state IDLE, cfg_dat=0, wr_pulse=0, counter=0; outputs HREADYOUT=1, HRESP=0, HRDATA=0. Reset during WAIT/ERR drops the transfer, no write.
- OKAY data phase length = WAIT_CYCLES+1 cycles; ERROR = exactly 2 cycles, never extended by WAIT_CYCLES.
- Back-to-back: accept in DATA/ERR2 cycle is legal (pipelined); write-then-read same register returns the new value with no extra stall.
- Master cancelling in ERR2 (HTRANS=IDLE) → IDLE, nothing accepted.
- Simultaneous: commit of transfer N and accept of N+1 on the same edge are independent.

## Structure
- Package ahb_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, HRESP OKAY/ERROR, FSM state enum, clog2 helper.
- Sub-module ahb_byte_lane_dec: HSIZE + HADDR[1:0] → 4-bit strobe + misalign flag; combinational, reused by later slaves.

## Test plan
- Reset, WAIT_CYCLES=0: word write 0xDEADBEEF to 0x04, read 0x04 → HRDATA 0xDEADBEEF, wr_pulse[1] one cycle, HREADYOUT never low.
- Byte write 0xAA to 0x09, halfword 0x1234 to 0x0A (reg 2 previously 0) → read 0x08 = 0x1234AA00.
- WAIT_CYCLES=3: write then read → HREADYOUT low exactly 3 cycles each, data valid on 4th.
- NUM_REGS=8: read 0x20 → ERR1 (HREADYOUT=0,HRESP=1), ERR2 (1,1); word write to 0x02 → same ERROR, no register change.
- RO_MASK=0x01, sts_dat[31:0]=0xCAFE0001: read 0x00 → 0xCAFE0001; write 0x00 → ERROR, no wr_pulse.
- HRESET asserted mid-WAIT of write 0xFFFFFFFF to 0x00 → cfg_dat slice 0 stays 0, HREADYOUT=1 next cycle.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and small helpers for the
// register-file slave family.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ahb_regfile_if.sv
// AHB-Lite bus bundle between a master (decoder/mux side) and a leaf slave.
interface ahb_regfile_if #(
    parameter int ADDR_W = 8
);
    logic              HSEL;
    logic              HREADY;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic [ADDR_W-1:0] HADDR;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport slave (
        input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_byte_lane_dec.sv
// Transfer size + low address bits to byte-lane strobes, with alignment
// and illegal-size flags. Purely combinational.
module ahb_byte_lane_dec
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       misalign,
    output logic       size_err
);

    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        size_err = 1'b0;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            HSIZE_WORD: begin
                strb     = 4'b1111;
                misalign = |addr_lo;
            end
            default: size_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_regfile.sv
// Parametrised AHB-Lite register file: RW config / RO status registers,
// sub-word writes, programmable wait states and two-cycle ERROR responses.
module ahb_regfile
    import ahb_pkg::*;
#(
    parameter int                  NUM_REGS    = 8,
    parameter int                  ADDR_W      = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  WAIT_CYCLES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_regfile_if.slave          bus,
    input  logic [32*NUM_REGS-1:0] sts_dat,
    output logic [32*NUM_REGS-1:0] cfg_dat,
    output logic [NUM_REGS-1:0]    wr_pulse
);

    localparam int             IDX_W     = ADDR_W - 2;
    localparam logic [IDX_W:0] NREGS     = (IDX_W+1)'(NUM_REGS);
    localparam logic [3:0]     WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic [3:0]         strb_q, strb_d;
    logic [31:0]        cfg_q [NUM_REGS];
    logic [31:0]        cfg_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    logic [IDX_W-1:0] idx_a;
    logic [3:0]       strb_a;
    logic             misalign_a, size_err_a, ro_a, err_a, accept;
    logic             hreadyout, hresp;
    logic [31:0]      rdata;
    logic             unused_htrans0;

    assign idx_a          = bus.HADDR[ADDR_W-1:2];
    assign accept         = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign unused_htrans0 = bus.HTRANS[0];

    ahb_byte_lane_dec u_lane_dec (
        .hsize    (bus.HSIZE),
        .addr_lo  (bus.HADDR[1:0]),
        .strb     (strb_a),
        .misalign (misalign_a),
        .size_err (size_err_a)
    );

    always_comb begin
        ro_a = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx_a == IDX_W'(i)) ro_a = RO_MASK[i];
        err_a = ({1'b0, idx_a} >= NREGS) | size_err_a | misalign_a | (bus.HWRITE & ro_a);
    end

    // Address phase is only sampled in states that present HREADYOUT=1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        strb_d    = strb_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                hresp = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                if (accept) begin
                    idx_d   = idx_a;
                    write_d = bus.HWRITE;
                    strb_d  = strb_a;
                    if (err_a) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Commit happens on the edge that ends the DATA cycle; HWDATA is valid then.
    always_comb begin
        cfg_d      = cfg_q;
        wr_pulse_d = '0;
        if (state_q == ST_DATA && write_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++)
                        if (strb_q[b]) cfg_d[i][8*b +: 8] = bus.HWDATA[8*b +: 8];
                    wr_pulse_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (state_q == ST_DATA && !write_q) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (idx_q == IDX_W'(i))
                    rdata = RO_MASK[i] ? sts_dat[32*i +: 32] : cfg_q[i];
        end
    end

    always_comb begin
        cfg_dat = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cfg_dat[32*i +: 32] = RO_MASK[i] ? 32'h0 : cfg_q[i];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            strb_q     <= 4'b0000;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            strb_q     <= strb_d;
            wr_pulse_q <= wr_pulse_d;
            cfg_q      <= cfg_d;
        end
    end

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = rdata;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_ahb_regfile.sv
// Directed bench for ahb_regfile: two instances (no-wait with RO reg 0,
// and three wait states) sharing bus inputs, with separate selects/resets.
module tb_ahb_regfile;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic [1:0]  hsel = 2'b00;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd0;
    logic        hwrite = 1'b0;
    logic [7:0]  haddr = 8'h00;
    logic [31:0] hwdata = 32'h0;

    logic [255:0] sts_dat0, sts_dat1, cfg_dat0, cfg_dat1;
    logic [7:0]   wr_pulse0, wr_pulse1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb_regfile_if #(.ADDR_W(8)) if0 ();
    ahb_regfile_if #(.ADDR_W(8)) if1 ();

    assign if0.HSEL   = hsel[0];
    assign if1.HSEL   = hsel[1];
    assign if0.HTRANS = htrans;   assign if1.HTRANS = htrans;
    assign if0.HSIZE  = hsize;    assign if1.HSIZE  = hsize;
    assign if0.HWRITE = hwrite;   assign if1.HWRITE = hwrite;
    assign if0.HADDR  = haddr;    assign if1.HADDR  = haddr;
    assign if0.HWDATA = hwdata;   assign if1.HWDATA = hwdata;
    assign if0.HREADY = if0.HREADYOUT;
    assign if1.HREADY = if1.HREADYOUT;

    assign sts_dat0 = {{7{32'h5A5A5A5A}}, 32'hCAFE0001};
    assign sts_dat1 = {8{32'hA5A5A5A5}};

    ahb_regfile #(.NUM_REGS(8), .ADDR_W(8), .RO_MASK(8'h01), .WAIT_CYCLES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst0), .bus(if0),
        .sts_dat(sts_dat0), .cfg_dat(cfg_dat0), .wr_pulse(wr_pulse0)
    );

    ahb_regfile #(.NUM_REGS(8), .ADDR_W(8), .RO_MASK(8'h00), .WAIT_CYCLES(3)) u_dut1 (
        .HCLK(clk), .HRESET(rst1), .bus(if1),
        .sts_dat(sts_dat1), .cfg_dat(cfg_dat1), .wr_pulse(wr_pulse1)
    );

    logic        rdy   [2];
    logic        resp  [2];
    logic [31:0] rdata [2];
    assign rdy[0] = if0.HREADYOUT;  assign rdy[1] = if1.HREADYOUT;
    assign resp[0] = if0.HRESP;     assign resp[1] = if1.HRESP;
    assign rdata[0] = if0.HRDATA;   assign rdata[1] = if1.HRDATA;

    typedef struct {
        int          d;
        logic        wr;
        logic [2:0]  sz;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        logic [31:0] cfg;
        logic [7:0]  pulse;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [31:0] cfg_slice(input int d, input int idx);
        return (d == 0) ? cfg_dat0[idx*32 +: 32] : cfg_dat1[idx*32 +: 32];
    endfunction

    function automatic logic [7:0] pulse_of(input int d);
        return (d == 0) ? wr_pulse0 : wr_pulse1;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int n;
        int idx;
        idx = int'(v.addr[4:2]);
        @(posedge clk); #1;
        hsel[v.d] = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.wr; hsize = v.sz;
        @(posedge clk); #1;
        hsel = 2'b00; htrans = 2'b00; hwdata = v.wd;
        @(negedge clk);
        if (v.err) begin
            chk($sformatf("v%0d_err1_ready", k), 32'(rdy[v.d]), 32'd0);
            chk($sformatf("v%0d_err1_resp", k), 32'(resp[v.d]), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_err2_ready", k), 32'(rdy[v.d]), 32'd1);
            chk($sformatf("v%0d_err2_resp", k), 32'(resp[v.d]), 32'd1);
        end else begin
            n = 0;
            while (rdy[v.d] == 1'b0 && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_stall", k), 32'(n), 32'(wait_of(v.d)));
            chk($sformatf("v%0d_resp", k), 32'(resp[v.d]), 32'd0);
            if (!v.wr) chk($sformatf("v%0d_rdata", k), rdata[v.d], v.rd);
        end
        @(negedge clk);
        chk($sformatf("v%0d_idle_resp", k), 32'(resp[v.d]), 32'd0);
        chk($sformatf("v%0d_idle_ready", k), 32'(rdy[v.d]), 32'd1);
        chk($sformatf("v%0d_pulse", k), 32'(pulse_of(v.d)), 32'(v.pulse));
        chk($sformatf("v%0d_cfg", k), cfg_slice(v.d, idx), v.cfg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            d  wr    sz    addr   wd            err   rd            cfg           pulse
        vecs[0]  = '{0, 1'b1, 3'd2, 8'h04, 32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF, 8'h02};
        vecs[1]  = '{0, 1'b0, 3'd2, 8'h04, 32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 8'h00};
        vecs[2]  = '{0, 1'b1, 3'd0, 8'h09, 32'h0000AA00, 1'b0, 32'h0,        32'h0000AA00, 8'h04};
        vecs[3]  = '{0, 1'b1, 3'd1, 8'h0A, 32'h12340000, 1'b0, 32'h0,        32'h1234AA00, 8'h04};
        vecs[4]  = '{0, 1'b0, 3'd2, 8'h08, 32'h0,        1'b0, 32'h1234AA00, 32'h1234AA00, 8'h00};
        vecs[5]  = '{0, 1'b0, 3'd2, 8'h20, 32'h0,        1'b1, 32'h0,        32'h00000000, 8'h00};
        vecs[6]  = '{0, 1'b1, 3'd2, 8'h06, 32'hFFFFFFFF, 1'b1, 32'h0,        32'hDEADBEEF, 8'h00};
        vecs[7]  = '{0, 1'b0, 3'd2, 8'h00, 32'h0,        1'b0, 32'hCAFE0001, 32'h00000000, 8'h00};
        vecs[8]  = '{0, 1'b1, 3'd2, 8'h00, 32'h11111111, 1'b1, 32'h0,        32'h00000000, 8'h00};
        vecs[9]  = '{0, 1'b1, 3'd3, 8'h0C, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h00000000, 8'h00};
        vecs[10] = '{0, 1'b1, 3'd1, 8'h0D, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h00000000, 8'h00};
        vecs[11] = '{0, 1'b0, 3'd1, 8'h0A, 32'h0,        1'b0, 32'h1234AA00, 32'h1234AA00, 8'h00};
        vecs[12] = '{0, 1'b1, 3'd0, 8'h1F, 32'h7F0000FF, 1'b0, 32'h0,        32'h7F000000, 8'h80};
        vecs[13] = '{0, 1'b0, 3'd2, 8'h1C, 32'h0,        1'b0, 32'h7F000000, 32'h7F000000, 8'h00};
        vecs[14] = '{0, 1'b1, 3'd1, 8'h0C, 32'hFFFFBEEF, 1'b0, 32'h0,        32'h0000BEEF, 8'h08};
        vecs[15] = '{1, 1'b1, 3'd2, 8'h10, 32'h55AA55AA, 1'b0, 32'h0,        32'h55AA55AA, 8'h10};
        vecs[16] = '{1, 1'b0, 3'd2, 8'h10, 32'h0,        1'b0, 32'h55AA55AA, 32'h55AA55AA, 8'h00};
        vecs[17] = '{1, 1'b1, 3'd2, 8'h02, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h00000000, 8'h00};
        vecs[18] = '{1, 1'b0, 3'd2, 8'h00, 32'h0,        1'b0, 32'h00000000, 32'h00000000, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_ready", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("rst%0d_resp", d), 32'(resp[d]), 32'd0);
            chk($sformatf("rst%0d_rdata", d), rdata[d], 32'h0);
            chk($sformatf("rst%0d_pulse", d), 32'(pulse_of(d)), 32'd0);
        end
        chk("rst0_cfg", 32'(|cfg_dat0), 32'd0);
        chk("rst1_cfg", 32'(|cfg_dat1), 32'd0);

        for (int k = 0; k < 19; k++) run_vec(k, vecs[k]);

        // Pipelined write then read of the same register, no stall between.
        @(posedge clk); #1;
        hsel[0] = 1'b1; htrans = 2'b10; haddr = 8'h14; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'h0BADF00D; hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_wr_ready", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;
        hsel = 2'b00; htrans = 2'b00;
        @(negedge clk);
        chk("b2b_rd_ready", 32'(rdy[0]), 32'd1);
        chk("b2b_rdata", rdata[0], 32'h0BADF00D);
        chk("b2b_pulse", 32'(wr_pulse0), 32'h20);
        chk("b2b_cfg", cfg_slice(0, 5), 32'h0BADF00D);
        @(negedge clk);
        chk("b2b_pulse_off", 32'(wr_pulse0), 32'd0);
        chk("b2b_rdata_idle", rdata[0], 32'h0);

        // Unaccepted transfers: BUSY with select, and NONSEQ without select.
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            hsel[0] = (t == 0); htrans = (t == 0) ? 2'b01 : 2'b10;
            haddr = 8'h14; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
            @(posedge clk); #1;
            hsel = 2'b00; htrans = 2'b00;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("noacc%0d_pulse", t), 32'(wr_pulse0), 32'd0);
            chk($sformatf("noacc%0d_cfg", t), cfg_slice(0, 5), 32'h0BADF00D);
            chk($sformatf("noacc%0d_ready", t), 32'(rdy[0]), 32'd1);
        end

        // Reset during the wait states of a write drops it.
        @(posedge clk); #1;
        hsel[1] = 1'b1; htrans = 2'b10; haddr = 8'h00; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 2'b00; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rstw_wait_ready", 32'(rdy[1]), 32'd0);
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(negedge clk);
        chk("rstw_ready", 32'(rdy[1]), 32'd1);
        chk("rstw_resp", 32'(resp[1]), 32'd0);
        chk("rstw_cfg", cfg_slice(1, 0), 32'h0);
        repeat (5) @(negedge clk);
        chk("rstw_cfg_late", cfg_slice(1, 0), 32'h0);
        chk("rstw_pulse_late", 32'(wr_pulse1), 32'd0);
        chk("rstw_dut0_kept", cfg_slice(0, 1), 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
